// File: rtl/unidade_execucao_if.sv
// Sequencer <-> execution-unit bus: opcode/operand/ALU-select inputs and result/status outputs.
// master = sequencer side, slave = unidade_execucao.
interface unidade_execucao_if #(
   parameter int W   = 5,
   parameter int OPW = 5
);
   logic [OPW-1:0] operacao;
   logic [W-1:0]   entrada;
   logic [1:0]     ula_sel;
   logic [W-1:0]   Tx;
   logic           tx_valid;
   logic           ovf;
   logic           seq_err;
   logic           busy;

   modport master (
      output operacao, entrada, ula_sel,
      input  Tx, tx_valid, ovf, seq_err, busy
   );

   modport slave (
      input  operacao, entrada, ula_sel,
      output Tx, tx_valid, ovf, seq_err, busy
   );
endinterface

// File: rtl/unidade_execucao.sv
// Execution stage: LOAD_A / LOAD_B / EXEC / STORE sequencing around a 4-function ALU.
// Optional macro SAT_EN makes add/sub saturate instead of wrapping.
//
// state     | meaning
// ----------+------------------------------------------
// S_IDLE    | no operand held, waiting for LOAD_A
// S_HAVE_A  | regA valid, waiting for LOAD_B
// S_HAVE_AB | regA/regB valid, waiting for EXEC
// S_HAVE_R  | regR valid, waiting for STORE
module unidade_execucao #(
   parameter int W   = 5,
   parameter int OPW = 5
) (
   input logic               clk,
   input logic               rst_n,
   unidade_execucao_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HAVE_A  = 2'd1,
      S_HAVE_AB = 2'd2,
      S_HAVE_R  = 2'd3
   } state_t;

   localparam logic [OPW-1:0] OP_NOP    = OPW'(0);
   localparam logic [OPW-1:0] OP_LOAD_A = OPW'(1);
   localparam logic [OPW-1:0] OP_LOAD_B = OPW'(2);
   localparam logic [OPW-1:0] OP_EXEC   = OPW'(3);
   localparam logic [OPW-1:0] OP_STORE  = OPW'(4);

   state_t         state_q, state_d;
   logic [W-1:0]   reg_a_q, reg_b_q, reg_r_q, tx_q;
   logic           tx_valid_q, ovf_q, seq_err_q, busy_q;

   logic           err;
   logic           ld_a, ld_b, do_exec, do_store;
   logic [W:0]     sum_w, diff_w;
   logic [W-1:0]   alu_res;
   logic           alu_ovf;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != S_IDLE);
      end
   end

   // Anything other than the one advancing op, a same-state reload, or NOP is an error.
   always_comb begin
      state_d = state_q;
      err     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.operacao == OP_LOAD_A)   state_d = S_HAVE_A;
            else if (bus.operacao != OP_NOP) err     = 1'b1;
         end
         S_HAVE_A: begin
            if (bus.operacao == OP_LOAD_B)   state_d = S_HAVE_AB;
            else if (bus.operacao != OP_NOP && bus.operacao != OP_LOAD_A) err = 1'b1;
         end
         S_HAVE_AB: begin
            if (bus.operacao == OP_EXEC)     state_d = S_HAVE_R;
            else if (bus.operacao != OP_NOP && bus.operacao != OP_LOAD_B) err = 1'b1;
         end
         S_HAVE_R: begin
            if (bus.operacao == OP_STORE)    state_d = S_IDLE;
            else if (bus.operacao != OP_NOP) err     = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            err     = 1'b1;
         end
      endcase
   end

   always_comb begin
      ld_a     = 1'b0;
      ld_b     = 1'b0;
      do_exec  = 1'b0;
      do_store = 1'b0;
      case (state_q)
         S_IDLE:    ld_a     = (bus.operacao == OP_LOAD_A);
         S_HAVE_A: begin
            ld_a = (bus.operacao == OP_LOAD_A);
            ld_b = (bus.operacao == OP_LOAD_B);
         end
         S_HAVE_AB: begin
            ld_b    = (bus.operacao == OP_LOAD_B);
            do_exec = (bus.operacao == OP_EXEC);
         end
         S_HAVE_R:  do_store = (bus.operacao == OP_STORE);
         default: ;
      endcase
   end

   always_comb begin
      sum_w   = {1'b0, reg_a_q} + {1'b0, reg_b_q};
      diff_w  = {1'b0, reg_a_q} - {1'b0, reg_b_q};
      alu_res = '0;
      alu_ovf = 1'b0;
      case (bus.ula_sel)
         2'd0: begin
            alu_ovf = sum_w[W];
`ifdef SAT_EN
            alu_res = sum_w[W] ? '1 : sum_w[W-1:0];
`else
            alu_res = sum_w[W-1:0];
`endif
         end
         2'd1: begin
            // top bit of the widened difference is the borrow
            alu_ovf = diff_w[W];
`ifdef SAT_EN
            alu_res = diff_w[W] ? '0 : diff_w[W-1:0];
`else
            alu_res = diff_w[W-1:0];
`endif
         end
         2'd2:    alu_res = reg_a_q & reg_b_q;
         default: alu_res = reg_a_q | reg_b_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reg_a_q    <= '0;
         reg_b_q    <= '0;
         reg_r_q    <= '0;
         tx_q       <= '0;
         tx_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         seq_err_q  <= 1'b0;
      end else begin
         if (ld_a) reg_a_q <= bus.entrada;
         if (ld_b) reg_b_q <= bus.entrada;
         if (do_exec) begin
            reg_r_q <= alu_res;
            ovf_q   <= alu_ovf;
         end
         if (do_store) tx_q <= reg_r_q;
         tx_valid_q <= do_store;
         if (err) seq_err_q <= 1'b1;
      end
   end

   assign bus.Tx       = tx_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.ovf      = ovf_q;
   assign bus.seq_err  = seq_err_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_unidade_execucao.sv
// Directed-vector bench for unidade_execucao; expectations are hand-computed constants.
// Build with +define+SAT_EN to check the saturating variant.
module tb_unidade_execucao;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   int   cyc;

   unidade_execucao_if #(.W(5), .OPW(5)) bus ();

   unidade_execucao #(.W(5), .OPW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic [4:0] op, input logic [4:0] ent, input logic [1:0] sel);
      bus.operacao = op;
      bus.entrada  = ent;
      bus.ula_sel  = sel;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(5'd0, 5'd0, 2'd0);
      step(5'd0, 5'd0, 2'd0);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.operacao = '0;
      bus.entrada  = '0;
      bus.ula_sel  = '0;
      do_reset();
      chk("reset Tx", bus.Tx, 5'd0);
      chk("reset tx_valid", {4'd0, bus.tx_valid}, 5'd0);
      chk("reset ovf", {4'd0, bus.ovf}, 5'd0);
      chk("reset seq_err", {4'd0, bus.seq_err}, 5'd0);
      chk("reset busy", {4'd0, bus.busy}, 5'd0);
   endtask

   task automatic test_basic_add();
      step(5'd1, 5'd4, 2'd0);
      chk("add4+6 busy after LOAD_A", {4'd0, bus.busy}, 5'd1);
      chk("add4+6 tx_valid after LOAD_A", {4'd0, bus.tx_valid}, 5'd0);
      step(5'd2, 5'd6, 2'd0);
      step(5'd3, 5'd0, 2'd0);
      chk("add4+6 ovf", {4'd0, bus.ovf}, 5'd0);
      chk("add4+6 Tx before STORE", bus.Tx, 5'd0);
      step(5'd4, 5'd0, 2'd0);
      chk("add4+6 Tx", bus.Tx, 5'd10);
      chk("add4+6 tx_valid pulse", {4'd0, bus.tx_valid}, 5'd1);
      chk("add4+6 busy after STORE", {4'd0, bus.busy}, 5'd0);
      step(5'd0, 5'd0, 2'd0);
      chk("add4+6 tx_valid drops", {4'd0, bus.tx_valid}, 5'd0);
      chk("add4+6 Tx held", bus.Tx, 5'd10);
      chk("add4+6 seq_err", {4'd0, bus.seq_err}, 5'd0);
   endtask

   task automatic run_seq(input logic [4:0] a, input logic [4:0] b, input logic [1:0] sel,
                          input string name, input logic [4:0] exp_tx, input logic exp_ovf);
      step(5'd1, a, 2'd0);
      step(5'd2, b, 2'd0);
      step(5'd3, 5'd0, sel);
      chk({name, " ovf"}, {4'd0, bus.ovf}, {4'd0, exp_ovf});
      step(5'd4, 5'd0, 2'd0);
      chk({name, " Tx"}, bus.Tx, exp_tx);
      chk({name, " tx_valid"}, {4'd0, bus.tx_valid}, 5'd1);
   endtask

   task automatic test_arith();
`ifdef SAT_EN
      run_seq(5'd20, 5'd15, 2'd0, "add20+15", 5'd31, 1'b1);
      run_seq(5'd4, 5'd6, 2'd1, "sub4-6", 5'd0, 1'b1);
`else
      run_seq(5'd20, 5'd15, 2'd0, "add20+15", 5'd3, 1'b1);
      run_seq(5'd4, 5'd6, 2'd1, "sub4-6", 5'd30, 1'b1);
`endif
      run_seq(5'd6, 5'd4, 2'd1, "sub6-4", 5'd2, 1'b0);
      run_seq(5'd9, 5'd3, 2'd2, "and9&3", 5'd1, 1'b0);
      // reload A in HAVE_A and B in HAVE_AB; last value wins
      step(5'd1, 5'd1, 2'd0);
      step(5'd1, 5'd16, 2'd0);
      step(5'd2, 5'd2, 2'd0);
      step(5'd2, 5'd8, 2'd0);
      step(5'd3, 5'd0, 2'd3);
      step(5'd4, 5'd0, 2'd0);
      chk("reload or16|8 Tx", bus.Tx, 5'd24);
      chk("reload seq_err", {4'd0, bus.seq_err}, 5'd0);
   endtask

   task automatic test_seq_err();
      do_reset();
      step(5'd3, 5'd0, 2'd0);
      chk("err EXEC in IDLE seq_err", {4'd0, bus.seq_err}, 5'd1);
      chk("err EXEC in IDLE busy", {4'd0, bus.busy}, 5'd0);
      step(5'd7, 5'd0, 2'd0);
      chk("err op7 seq_err", {4'd0, bus.seq_err}, 5'd1);
      chk("err op7 Tx", bus.Tx, 5'd0);
      chk("err op7 tx_valid", {4'd0, bus.tx_valid}, 5'd0);
      chk("err op7 busy", {4'd0, bus.busy}, 5'd0);
      step(5'd1, 5'd9, 2'd0);
      step(5'd1, 5'd12, 2'd0);
      step(5'd2, 5'd5, 2'd0);
      step(5'd1, 5'd0, 2'd0);
      chk("err LOAD_A in HAVE_AB busy", {4'd0, bus.busy}, 5'd1);
      step(5'd3, 5'd0, 2'd0);
      step(5'd4, 5'd0, 2'd0);
      chk("err recovery Tx 12+5", bus.Tx, 5'd17);
      chk("err recovery tx_valid", {4'd0, bus.tx_valid}, 5'd1);
      chk("err sticky", {4'd0, bus.seq_err}, 5'd1);
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(5'd1, 5'd4, 2'd0);
      step(5'd2, 5'd6, 2'd0);
      rst_n = 1'b0;
      step(5'd0, 5'd0, 2'd0);
      chk("midrst busy", {4'd0, bus.busy}, 5'd0);
      rst_n = 1'b1;
      step(5'd3, 5'd0, 2'd0);
      chk("midrst EXEC seq_err", {4'd0, bus.seq_err}, 5'd1);
      step(5'd4, 5'd0, 2'd0);
      chk("midrst STORE Tx", bus.Tx, 5'd0);
      chk("midrst STORE tx_valid", {4'd0, bus.tx_valid}, 5'd0);
      chk("midrst seq_err", {4'd0, bus.seq_err}, 5'd1);
   endtask

   task automatic test_back_to_back();
      int pulses;
      int last_pulse;
      logic [4:0] ops [5];
      logic [4:0] ents [5];
      logic       exp_busy [5];
      ops  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4};
      ents = '{5'd0, 5'd4, 5'd6, 5'd0, 5'd0};
      exp_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      pulses = 0;
      last_pulse = -1;
      do_reset();
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 5; k++) begin
            step(ops[k], ents[k], 2'd3);
            chk($sformatf("b2b r%0d k%0d busy", r, k), {4'd0, bus.busy}, {4'd0, exp_busy[k]});
            chk($sformatf("b2b r%0d k%0d tx_valid", r, k), {4'd0, bus.tx_valid},
                {4'd0, (k == 4)});
            if (bus.tx_valid === 1'b1) begin
               pulses++;
               chk($sformatf("b2b r%0d Tx", r), bus.Tx, 5'd6);
               if (last_pulse >= 0)
                  chk($sformatf("b2b r%0d pulse spacing", r), 5'(cyc - last_pulse), 5'd5);
               last_pulse = cyc;
            end
         end
      end
      chk("b2b pulse count", 5'(pulses), 5'd3);
      chk("b2b seq_err", {4'd0, bus.seq_err}, 5'd0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      rst_n       = 1'b0;
      test_reset();
      test_basic_add();
      test_arith();
      test_seq_err();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
